tx_fifo_write_arbiter: RTL and testbench

- Shares the single write port of the TX asynchronous FIFO (Winc / Wrdata / Wfull, `Ref_clk` domain) among several byte-producing requesters. Requesters include ALU result, register-read response and status/error reporter.
- Grants are round-robin. Each granted burst is one or two bytes, written atomically and LSB first, with back-pressure from FIFO full.
- The block sits between the system controller's response sources and the FIFO write side.

---
 rtl/tx_fifo_write_arbiter_pkg.sv | 22 ++
 rtl/tx_fifo_write_arbiter_rr_grant_sel.sv | 30 +++
 rtl/tx_fifo_write_arbiter.sv | 139 +++++++++++++
 tb/tb_tx_fifo_write_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_fifo_write_arbiter_pkg.sv
// Shared definitions for the TX FIFO write arbiter: state encoding, burst length codes, default byte width.
package tx_fifo_write_arbiter_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   // REQ_LEN encoding
   localparam logic LEN_1B = 1'b0;
   localparam logic LEN_2B = 1'b1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SEND_LO = 2'd1;
   localparam logic [1:0] ST_SEND_HI = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      SEND_LO = ST_SEND_LO,
      SEND_HI = ST_SEND_HI,
      DONE    = ST_DONE
   } arb_state_e;

endpackage

// File: rtl/tx_fifo_write_arbiter_rr_grant_sel.sv
// rr_grant_sel: combinational round-robin pick of the first set request above last_grant, wrapping.
// Stateless so any arbiter can reuse it with its own last_grant register.
module rr_grant_sel #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               any_req
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every always_comb output gets a default first, otherwise a missed path infers a latch.
      grant   = '0;
      any_req = 1'b0;
      idx     = '0;
      // Scan from the farthest candidate down so the nearest one above last_grant wins.
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
         if (req[idx]) begin
            grant   = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_fifo_write_arbiter.sv
// Round-robin arbiter sharing the TX async FIFO write port; each grant writes 1 or 2 bytes atomically, LSB first.
// Build macro TX_ARB_TIMEOUT_EN: abort a burst with DROP after TIMEOUT_CYCLES consecutive FIFO_full cycles.
module tx_fifo_write_arbiter
   import tx_fifo_write_arbiter_pkg::*;
#(
   parameter int Data_width     = DEFAULT_DATA_WIDTH,
   parameter int NUM_REQ        = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [NUM_REQ-1:0]              REQ,
   input  logic [NUM_REQ*2*Data_width-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]              REQ_LEN,
   output logic [NUM_REQ-1:0]              ACK,
   output logic [NUM_REQ-1:0]              DROP,
   input  logic                            FIFO_full,
   output logic [Data_width-1:0]           TX_p_data,
   output logic                            TX_d_valid,
   output logic                            busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("tx_fifo_write_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
   end

   arb_state_e            state;
   logic [IDX_W-1:0]      last_grant;
   logic [IDX_W-1:0]      grant;
   logic [IDX_W-1:0]      next_grant;
   logic                  any_req;
   logic [Data_width-1:0] hold_lo;
   logic [Data_width-1:0] hold_hi;
   logic                  hold_len;
   logic                  in_send;
   logic                  timeout_hit;

   rr_grant_sel #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_grant_sel (
      .req        (REQ),
      .last_grant (last_grant),
      .grant      (next_grant),
      .any_req    (any_req)
   );

   assign in_send = (state == SEND_LO) || (state == SEND_HI);

   // FIFO_full reaches Winc combinationally so no write is ever issued into a full FIFO.
   assign TX_d_valid = in_send && !FIFO_full;
   assign TX_p_data  = (state == SEND_LO) ? hold_lo :
                       (state == SEND_HI) ? hold_hi : '0;

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] full_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive full cycle of a burst.
   assign timeout_hit = in_send && FIFO_full && (full_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         full_cnt <= '0;
      end else if (!in_send || !FIFO_full || timeout_hit) begin
         full_cnt <= '0;
      end else begin
         full_cnt <= full_cnt + CNT_W'(1);
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (RST) begin
         state      <= IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         grant      <= '0;
         // NOTE: the holding registers are plain flops, reset so TX_p_data is defined out of reset.
         hold_lo    <= '0;
         hold_hi    <= '0;
         hold_len   <= LEN_1B;
         ACK        <= '0;
         DROP       <= '0;
         busy       <= 1'b0;
      end else begin
         ACK  <= '0;
         DROP <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant                <= next_grant;
                  {hold_hi, hold_lo}   <= REQ_DATA[int'(next_grant)*2*Data_width +: 2*Data_width];
                  hold_len             <= REQ_LEN[next_grant];
                  state                <= SEND_LO;
                  busy                 <= 1'b1;
               end
            end
            SEND_LO: begin
               if (!FIFO_full) begin
                  if (hold_len == LEN_2B) begin
                     state <= SEND_HI;
                  end else begin
                     state <= DONE;
                     ACK   <= NUM_REQ'(1) << grant;
                  end
               end else if (timeout_hit) begin
                  state <= DONE;
                  DROP  <= NUM_REQ'(1) << grant;
               end
            end
            SEND_HI: begin
               if (!FIFO_full) begin
                  state <= DONE;
                  ACK   <= NUM_REQ'(1) << grant;
               end else if (timeout_hit) begin
                  state <= DONE;
                  DROP  <= NUM_REQ'(1) << grant;
               end
            end
            DONE: begin
               last_grant <= grant;
               state      <= IDLE;
               busy       <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_fifo_write_arbiter.sv
// Directed bench for tx_fifo_write_arbiter: inputs change 1 ns after the rising edge, outputs are sampled on the falling edge.
// Cycle c of a scenario is the clock period after edge c-1; the first request is sampled at edge 0.
module tb_tx_fifo_write_arbiter;

   logic        CLK;
   logic        RST;
   logic [2:0]  REQ;
   logic [47:0] REQ_DATA;
   logic [2:0]  REQ_LEN;
   logic [2:0]  ACK;
   logic [2:0]  DROP;
   logic        FIFO_full;
   logic [7:0]  TX_p_data;
   logic        TX_d_valid;
   logic        busy;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       busy;
      logic       vld;
      logic [7:0] data;
      logic [2:0] ack;
      logic [2:0] drop;
   } obs_t;

   tx_fifo_write_arbiter #(
      .Data_width     (8),
      .NUM_REQ        (3),
      .TIMEOUT_CYCLES (5)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .REQ        (REQ),
      .REQ_DATA   (REQ_DATA),
      .REQ_LEN    (REQ_LEN),
      .ACK        (ACK),
      .DROP       (DROP),
      .FIFO_full  (FIFO_full),
      .TX_p_data  (TX_p_data),
      .TX_d_valid (TX_d_valid),
      .busy       (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1);
   end

   // Data only matters when a write is strobed.
   function automatic obs_t observe();
      obs_t o;
      o.busy = busy;
      o.vld  = TX_d_valid;
      o.data = TX_d_valid ? TX_p_data : 8'h00;
      o.ack  = ACK;
      o.drop = DROP;
      return o;
   endfunction

   function automatic obs_t e(input logic b, input logic v, input logic [7:0] d,
                              input logic [2:0] a, input logic [2:0] dr);
      obs_t o;
      o.busy = b;
      o.vld  = v;
      o.data = d;
      o.ack  = a;
      o.drop = dr;
      return o;
   endfunction

   task automatic advance();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST       = 1'b1;
      REQ       = 3'b000;
      REQ_LEN   = 3'b000;
      REQ_DATA  = '0;
      FIFO_full = 1'b0;
      advance();
      advance();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] raw;
      RST       = 1'b1;
      REQ       = 3'b000;
      REQ_LEN   = 3'b000;
      REQ_DATA  = '0;
      FIFO_full = 1'b0;
      sample();
      raw = {busy, TX_d_valid, TX_p_data, ACK, DROP};
      checks++;
      if (raw !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got busy=%b vld=%b data=%h ack=%b drop=%b, want all zero",
                  busy, TX_d_valid, TX_p_data, ACK, DROP);
      end
      do_reset();
   endtask

   task automatic test_two_byte();
      obs_t got, want;
      do_reset();
      REQ      = 3'b001;
      REQ_LEN  = 3'b001;
      REQ_DATA = {16'h0000, 16'h0000, 16'hA55A};
      for (int c = 0; c < 6; c++) begin
         if (c > 0) advance();
         if (c == 4) REQ = 3'b000;
         sample();
         case (c)
            1:       want = e(1'b1, 1'b1, 8'h5A, 3'b000, 3'b000);
            2:       want = e(1'b1, 1'b1, 8'hA5, 3'b000, 3'b000);
            3:       want = e(1'b1, 1'b0, 8'h00, 3'b001, 3'b000);
            default: want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         endcase
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL two_byte c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
   endtask

   task automatic test_round_robin();
      obs_t       got, want;
      logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
      int         ph, idx;
      do_reset();
      REQ      = 3'b111;
      REQ_LEN  = 3'b000;
      REQ_DATA = {16'hEE33, 16'hEE22, 16'hEE11};
      // Each one-byte burst takes three cycles: capture, write, ACK.
      for (int c = 0; c < 14; c++) begin
         if (c > 0) advance();
         if (c == 12) REQ = 3'b000;
         sample();
         ph  = (c - 1) % 3;
         idx = ((c - 1) / 3) % 3;
         if (c == 0 || c >= 12 || ph == 2) begin
            want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         end else if (ph == 0) begin
            want = e(1'b1, 1'b1, bytes[idx], 3'b000, 3'b000);
         end else begin
            want = e(1'b1, 1'b0, 8'h00, 3'(1 << idx), 3'b000);
         end
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL round_robin c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
   endtask

   task automatic test_stall();
      obs_t got, want;
      do_reset();
      REQ      = 3'b010;
      REQ_LEN  = 3'b010;
      REQ_DATA = {16'h0000, 16'hC33C, 16'h0000};
      for (int c = 0; c < 9; c++) begin
         if (c > 0) advance();
         FIFO_full = (c >= 2 && c <= 5);
         if (c == 8) REQ = 3'b000;
         sample();
         case (c)
            1:             want = e(1'b1, 1'b1, 8'h3C, 3'b000, 3'b000);
            2, 3, 4, 5:    want = e(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
            6:             want = e(1'b1, 1'b1, 8'hC3, 3'b000, 3'b000);
            7:             want = e(1'b1, 1'b0, 8'h00, 3'b010, 3'b000);
            default:       want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         endcase
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL stall c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
   endtask

   task automatic test_req_drop();
      obs_t got, want;
      do_reset();
      REQ      = 3'b010;
      REQ_LEN  = 3'b010;
      REQ_DATA = {16'h0000, 16'hBEEF, 16'h0000};
      for (int c = 0; c < 6; c++) begin
         if (c > 0) advance();
         if (c == 1) begin
            REQ      = 3'b000;
            REQ_LEN  = 3'b000;
            REQ_DATA = {16'h0000, 16'h1234, 16'h0000};
         end
         sample();
         case (c)
            1:       want = e(1'b1, 1'b1, 8'hEF, 3'b000, 3'b000);
            2:       want = e(1'b1, 1'b1, 8'hBE, 3'b000, 3'b000);
            3:       want = e(1'b1, 1'b0, 8'h00, 3'b010, 3'b000);
            default: want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         endcase
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL req_drop c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
   endtask

   task automatic test_full_stuck();
      obs_t got, want;
      int   n;
      do_reset();
      REQ      = 3'b001;
      REQ_LEN  = 3'b000;
      REQ_DATA = {16'h0000, 16'h0000, 16'h00A5};
`ifdef TX_ARB_TIMEOUT_EN
      n = 9;
`else
      n = 24;
`endif
      for (int c = 0; c < n; c++) begin
         if (c > 0) advance();
`ifdef TX_ARB_TIMEOUT_EN
         // Five full cycles in SEND_LO, then DROP with no write and no ACK.
         FIFO_full = (c >= 1 && c <= 6);
         if (c == 7) REQ = 3'b000;
         sample();
         if (c >= 1 && c <= 5)  want = e(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
         else if (c == 6)       want = e(1'b1, 1'b0, 8'h00, 3'b000, 3'b001);
         else                   want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
`else
         // Without the abort feature the burst waits out the stall, then completes.
         FIFO_full = (c >= 1 && c <= 20);
         if (c == 23) REQ = 3'b000;
         sample();
         if (c >= 1 && c <= 20) want = e(1'b1, 1'b0, 8'h00, 3'b000, 3'b000);
         else if (c == 21)      want = e(1'b1, 1'b1, 8'hA5, 3'b000, 3'b000);
         else if (c == 22)      want = e(1'b1, 1'b0, 8'h00, 3'b001, 3'b000);
         else                   want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
`endif
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL full_stuck c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
      FIFO_full = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      obs_t        got, want;
      logic [15:0] raw;
      do_reset();
      REQ      = 3'b001;
      REQ_LEN  = 3'b001;
      REQ_DATA = {16'h0000, 16'h0000, 16'h7788};
      for (int c = 0; c < 3; c++) begin
         if (c > 0) advance();
         sample();
         case (c)
            1:       want = e(1'b1, 1'b1, 8'h88, 3'b000, 3'b000);
            2:       want = e(1'b1, 1'b1, 8'h77, 3'b000, 3'b000);
            default: want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         endcase
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid pre c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
      // Reset lands mid-period while SEND_HI is writing; outputs must clear without a clock edge.
      #1;
      RST = 1'b1;
      #1;
      raw = {busy, TX_d_valid, TX_p_data, ACK, DROP};
      checks++;
      if (raw !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid async: got busy=%b vld=%b data=%h ack=%b drop=%b, want all zero",
                  busy, TX_d_valid, TX_p_data, ACK, DROP);
      end
      advance();
      RST      = 1'b0;
      REQ      = 3'b110;
      REQ_LEN  = 3'b000;
      REQ_DATA = {16'h0066, 16'h0055, 16'h0044};
      for (int c = 0; c < 4; c++) begin
         if (c > 0) advance();
         if (c == 3) REQ = 3'b000;
         sample();
         case (c)
            1:       want = e(1'b1, 1'b1, 8'h55, 3'b000, 3'b000);
            2:       want = e(1'b1, 1'b0, 8'h00, 3'b010, 3'b000);
            default: want = e(1'b0, 1'b0, 8'h00, 3'b000, 3'b000);
         endcase
         got = observe();
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL reset_mid post c%0d: got busy=%b vld=%b data=%h ack=%b drop=%b, want busy=%b vld=%b data=%h ack=%b drop=%b",
                     c, got.busy, got.vld, got.data, got.ack, got.drop,
                     want.busy, want.vld, want.data, want.ack, want.drop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_byte();
      test_round_robin();
      test_stall();
      test_req_drop();
      test_full_stuck();
      test_reset_mid_burst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
